psum_requant_drain: RTL
=======================

Name: psum_requant_drain

Overview:
- Downstream stage of the 4x4 systolic PE array.
- When the controller signals that accumulation is complete, it snapshots all 16 32-bit partial sums in one cycle, freeing the array for the next tile.
- Each sum is requantized to int8: per-row bias, rounding right shift, optional ReLU, saturation.
- Results stream out one PE row per handshake (4 packed int8) toward the output feature buffer.

Parameters:
- ACC_WIDTH, 32, width of each partial sum and bias.
- OUT_WIDTH, 8, width of each requantized output element.
- ARRAY_SIZE, 4, PE rows/cols; outputs per row and rows per tile.
- SHIFT_WIDTH, 5, width of the shift amount.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- psum_valid  in  1  pe_results holds a finished tile.
- psum_ready  out  1  block can capture a tile.
- pe_results  in  ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH  packed sums; element k = PE(k/ARRAY_SIZE, k%ARRAY_SIZE), k=0 at LSBs.
- bias  in  ARRAY_SIZE*ACC_WIDTH  signed per-row bias; row i at bits [(i+1)*ACC_WIDTH-1 : i*ACC_WIDTH].
- out_shift  in  SHIFT_WIDTH  arithmetic right-shift amount, 0..31.
- relu_en  in  1  clamp negatives to 0.
- out_valid  out  1  out_data holds a valid row.
- out_ready  in  1  consumer accepts the row.
- out_data  out  ARRAY_SIZE*OUT_WIDTH  signed int8 per column; column j at bits [(j+1)*OUT_WIDTH-1 : j*OUT_WIDTH].
- out_row  out  log2(ARRAY_SIZE)  index of the row on out_data.
- out_last  out  1  asserted with the final row (out_row == ARRAY_SIZE-1).

Behaviour:
- Reset: all outputs 0 except psum_ready=1; state IDLE; buffers cleared.
- Reset mid-drain: the pending tile is discarded.
- States: IDLE and DRAIN.
- psum_ready = (state == IDLE), a registered decode.
- A capture occurs at an edge where psum_valid & psum_ready.
- On capture:
  - Latch all 16 sums plus bias, out_shift and relu_en into snapshot registers.
  - Later changes on those inputs do not affect this tile.
  - Go to DRAIN with row_ptr=0.
  - Register row 0 into the output regs at the same edge, computed combinationally from the live inputs.
  - Result: out_valid=1, out_row=0 the cycle after the capture edge (latency 1).
- In DRAIN, on an edge where out_valid & out_ready:
  - If out_row < ARRAY_SIZE-1: load the next row from the snapshot. out_valid stays 1, giving back-to-back rows with no bubble.
  - If out_row == ARRAY_SIZE-1: out_valid=0, out_last=0, state IDLE. psum_ready=1 in the following cycle.
- When out_valid=1 and out_ready=0: out_data, out_row and out_last hold stable.
- psum_valid while in DRAIN is ignored; no capture occurs and the upstream holds.
- Minimum tile period: 1 + ARRAY_SIZE cycles.
- Per-element arithmetic (signed):
  - s = sext(psum) + sext(bias[row]), ACC_WIDTH+1 bits.
  - If shift > 0: r = (s + 2^(shift-1)) >>> shift, computed in ACC_WIDTH+2 bits, round half toward +inf. If shift == 0: r = s.
  - If relu_en and r < 0: r = 0.
  - Saturate r to [-128, 127].

Decomposition:
- Shared package quant_pkg:
  - ACC_WIDTH, OUT_WIDTH and SHIFT_WIDTH constants.
  - State encoding: IDLE=0, DRAIN=1.
  - Saturation bounds QMIN=-128, QMAX=127.
- Sub-module requant_lane: purely combinational single-element bias/round/shift/ReLU/saturate. Instantiated ARRAY_SIZE times on the selected row.
- The parent holds the FSM, row_ptr, snapshot and output registers.

Test Plan:
- Basic tile:
  - Stimulus: all psums=10*(k+1), bias=0, shift=0, relu=0, out_ready=1.
  - Response: 4 consecutive valid rows one cycle after capture. Row 0 = {10,20,30,40}, row 3 = {127,127,127,127}. out_last only on row 3. psum_ready returns 1 after 5 cycles.
- Rounding/shift:
  - Stimulus: psum=-5 and psum=5, shift=1.
  - Response: -2 and 3 (half up). psum=6, shift=2 -> 2 (6+2=8, >>>2).
- Bias, ReLU and saturation:
  - Stimulus: bias row1=-1000, psums row1=100, relu=1.
  - Response: row1 all 0.
  - Stimulus: same with relu=0.
  - Response: -128. Also psum=0x7FFFFFFF with bias=1 -> 127, with no 32-bit wrap.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,...
  - Response: out_data/out_row stable while stalled; no row lost or duplicated; order 0..3.
- Capture isolation:
  - Stimulus: change pe_results, bias and shift, and hold psum_valid=1, during DRAIN.
  - Response: the current tile's outputs are unaffected. The second tile is captured only on the cycle psum_ready=1.
- Reset mid-drain:
  - Stimulus: assert rst after row 1 is accepted.
  - Response: next cycle out_valid=0, psum_ready=1, out_row=0. A new tile then drains from row 0.

Source files
------------

// File: rtl/quant_pkg.sv
// Shared constants and types for the partial-sum requantization drain.
`timescale 1ns/1ps
package quant_pkg;
   localparam int ACC_WIDTH   = 32;
   localparam int OUT_WIDTH   = 8;
   localparam int SHIFT_WIDTH = 5;
   localparam int ARRAY_SIZE  = 4;
   localparam int ROW_WIDTH   = $clog2(ARRAY_SIZE);
   // Two guard bits: one for the bias add, one for the rounding add.
   localparam int WIDE_WIDTH  = ACC_WIDTH + 2;

   localparam int QMIN = -128;
   localparam int QMAX = 127;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_e;

   typedef logic signed [WIDE_WIDTH-1:0] wide_t;
endpackage

// File: rtl/requant_lane.sv
// One output element: bias add, round-half-up arithmetic shift, optional ReLU, int8 saturation.
`timescale 1ns/1ps
module requant_lane
   import quant_pkg::*;
(
   input  logic signed [ACC_WIDTH-1:0]   psum_i,
   input  logic signed [ACC_WIDTH-1:0]   bias_i,
   input  logic        [SHIFT_WIDTH-1:0] shift_i,
   input  logic                          relu_en_i,
   output logic        [OUT_WIDTH-1:0]   q_o
);
   wide_t sum_w;
   wide_t rnd_w;
   wide_t res_w;

   always_comb begin
      sum_w = wide_t'(psum_i) + wide_t'(bias_i);
      rnd_w = '0;
      res_w = sum_w;
      if (shift_i != '0) begin
         rnd_w = wide_t'(1) <<< (shift_i - SHIFT_WIDTH'(1));
         res_w = (sum_w + rnd_w) >>> shift_i;
      end
      if (relu_en_i && (res_w < 0)) begin
         res_w = '0;
      end
      if (res_w > wide_t'(QMAX)) begin
         q_o = OUT_WIDTH'(QMAX);
      end else if (res_w < wide_t'(QMIN)) begin
         q_o = OUT_WIDTH'(QMIN);
      end else begin
         q_o = res_w[OUT_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/psum_requant_drain.sv
// Snapshots a finished PE tile in one cycle, then streams requantized rows (one per handshake).
`timescale 1ns/1ps
module psum_requant_drain
   import quant_pkg::*;
(
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       psum_valid,
   output logic                                       psum_ready,
   input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] pe_results,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]            bias,
   input  logic [SHIFT_WIDTH-1:0]                     out_shift,
   input  logic                                       relu_en,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [ARRAY_SIZE*OUT_WIDTH-1:0]            out_data,
   output logic [ROW_WIDTH-1:0]                       out_row,
   output logic                                       out_last,
   output state_e                                     dbg_state
);
   // Handshakes: a transfer happens on an edge where valid and ready are both 1;
   // out_valid/out_data/out_row/out_last are held stable until that transfer.
   localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(ARRAY_SIZE - 1);

   state_e                                     state_q;
   logic                                       psum_ready_q;
   logic                                       out_valid_q;
   logic [ARRAY_SIZE*OUT_WIDTH-1:0]            out_data_q;
   logic [ROW_WIDTH-1:0]                       out_row_q;
   logic                                       out_last_q;
   logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] snap_psum_q;
   logic [ARRAY_SIZE*ACC_WIDTH-1:0]            snap_bias_q;
   logic [SHIFT_WIDTH-1:0]                     snap_shift_q;
   logic                                       snap_relu_q;

   logic [ROW_WIDTH-1:0]                       row_sel;
   logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] src_psum;
   logic [ARRAY_SIZE*ACC_WIDTH-1:0]            src_bias;
   logic [SHIFT_WIDTH-1:0]                     src_shift;
   logic                                       src_relu;
   logic [ACC_WIDTH-1:0]                       row_bias;
   logic [ACC_WIDTH-1:0]                       lane_psum [ARRAY_SIZE];
   logic [ARRAY_SIZE*OUT_WIDTH-1:0]            lane_q;

   // Row 0 is computed from the live inputs at capture; later rows come from the snapshot.
   always_comb begin
      if (state_q == S_IDLE) begin
         row_sel   = '0;
         src_psum  = pe_results;
         src_bias  = bias;
         src_shift = out_shift;
         src_relu  = relu_en;
      end else begin
         row_sel   = out_row_q + ROW_WIDTH'(1);
         src_psum  = snap_psum_q;
         src_bias  = snap_bias_q;
         src_shift = snap_shift_q;
         src_relu  = snap_relu_q;
      end
      row_bias = src_bias[int'(row_sel)*ACC_WIDTH +: ACC_WIDTH];
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         lane_psum[j] = src_psum[(int'(row_sel)*ARRAY_SIZE + j)*ACC_WIDTH +: ACC_WIDTH];
      end
   end

   for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
      requant_lane u_lane (
         .psum_i    (lane_psum[j]),
         .bias_i    (row_bias),
         .shift_i   (src_shift),
         .relu_en_i (src_relu),
         .q_o       (lane_q[j*OUT_WIDTH +: OUT_WIDTH])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         psum_ready_q <= 1'b1;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_row_q    <= '0;
         out_last_q   <= 1'b0;
         snap_psum_q  <= '0;
         snap_bias_q  <= '0;
         snap_shift_q <= '0;
         snap_relu_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (psum_valid && psum_ready_q) begin
                  snap_psum_q  <= pe_results;
                  snap_bias_q  <= bias;
                  snap_shift_q <= out_shift;
                  snap_relu_q  <= relu_en;
                  state_q      <= S_DRAIN;
                  psum_ready_q <= 1'b0;
                  out_valid_q  <= 1'b1;
                  out_data_q   <= lane_q;
                  out_row_q    <= row_sel;
                  out_last_q   <= (row_sel == LAST_ROW);
               end
            end
            S_DRAIN: begin
               if (out_valid_q && out_ready) begin
                  if (out_row_q == LAST_ROW) begin
                     state_q      <= S_IDLE;
                     psum_ready_q <= 1'b1;
                     out_valid_q  <= 1'b0;
                     out_row_q    <= '0;
                     out_last_q   <= 1'b0;
                  end else begin
                     out_data_q <= lane_q;
                     out_row_q  <= row_sel;
                     out_last_q <= (row_sel == LAST_ROW);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign psum_ready = psum_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_row    = out_row_q;
   assign out_last   = out_last_q;
   assign dbg_state  = state_q;
endmodule
